imem_responder: RTL and testbench

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/imem_responder_if.sv | 24 ++
 rtl/imem_responder.sv | 121 ++++++++++++
 tb/tb_imem_responder.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/imem_responder_if.sv
// Fetch-side request/response and byte-wide RAM port bundle for imem_responder.
interface imem_responder_if #(
  parameter int MEM_ADDR_BITS = 17
);
  logic                     asking;
  logic [31:0]              addr;
  logic                     flush;
  logic [7:0]               mem_din;
  logic [MEM_ADDR_BITS-1:0] mem_a;
  logic                     mem_rd;
  logic [31:0]              data;
  logic                     data_ready;
  logic                     busy;

  modport slave (
    input  asking, addr, flush, mem_din,
    output mem_a, mem_rd, data, data_ready, busy
  );

  modport master (
    output asking, addr, flush, mem_din,
    input  mem_a, mem_rd, data, data_ready, busy
  );
endinterface

// File: rtl/imem_responder.sv
// Instruction fetch responder: reads 2 or 4 bytes from a byte-wide synchronous RAM
// and returns a little-endian instruction word, with a one-entry newest-wins pending slot.
module imem_responder #(
  parameter int MEM_ADDR_BITS = 17
) (
  input logic              clk,
  input logic              rst,
  imem_responder_if.slave  bus
);
  localparam int AW = MEM_ADDR_BITS;

  typedef enum logic {IDLE, READ} state_t;

  state_t        state, state_nx;
  logic [1:0]    issue_cnt, cap_cnt;
  logic          byte_valid;
  logic [23:0]   staged;
  logic          pend_valid;
  logic [AW-1:0] pend_addr;
  logic          complete, compressed, start;
  logic [AW-1:0] start_addr;

  if (AW < 32) begin : g_unused
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.addr[31:AW];
  end

  assign bus.busy = (state == READ) || pend_valid;

  always_comb begin
    compressed = (cap_cnt == 2'd1) && (staged[1:0] != 2'b11);
    complete   = (state == READ) && byte_valid && (compressed || (cap_cnt == 2'd3));
    start      = 1'b0;
    start_addr = bus.addr[AW-1:0];
    state_nx   = state;
    case (state)
      IDLE: if (bus.asking) begin
        start    = 1'b1;
        state_nx = READ;
      end
      READ: if (complete) begin
        // A queued request takes precedence; a fresh ask then refills the slot.
        if (pend_valid) begin
          start      = 1'b1;
          start_addr = pend_addr;
        end else if (bus.asking) begin
          start = 1'b1;
        end
        state_nx = start ? READ : IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (bus.flush) begin
      start      = bus.asking;
      start_addr = bus.addr[AW-1:0];
      state_nx   = bus.asking ? READ : IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      issue_cnt      <= '0;
      cap_cnt        <= '0;
      byte_valid     <= 1'b0;
      staged         <= '0;
      pend_valid     <= 1'b0;
      pend_addr      <= '0;
      bus.mem_a      <= '0;
      bus.mem_rd     <= 1'b0;
      bus.data       <= '0;
      bus.data_ready <= 1'b0;
    end else begin
      state          <= state_nx;
      bus.data_ready <= complete && !bus.flush;
      if (complete && !bus.flush)
        bus.data <= compressed ? {16'h0000, bus.mem_din, staged[7:0]}
                               : {bus.mem_din, staged};

      if (start) begin
        bus.mem_a  <= start_addr;
        bus.mem_rd <= 1'b1;
        issue_cnt  <= '0;
        cap_cnt    <= '0;
        byte_valid <= 1'b0;
      end else if (bus.flush || complete) begin
        bus.mem_rd <= 1'b0;
        byte_valid <= 1'b0;
      end else if (state == READ) begin
        // mem_din is valid one cycle after the address it answers was issued.
        byte_valid <= bus.mem_rd;
        if (bus.mem_rd) begin
          if (issue_cnt == 2'd3) begin
            bus.mem_rd <= 1'b0;
          end else begin
            bus.mem_a <= bus.mem_a + 1'b1;
            issue_cnt <= issue_cnt + 2'd1;
          end
        end
        if (byte_valid) begin
          case (cap_cnt)
            2'd0:    staged[7:0]   <= bus.mem_din;
            2'd1:    staged[15:8]  <= bus.mem_din;
            2'd2:    staged[23:16] <= bus.mem_din;
            default: ;
          endcase
          cap_cnt <= cap_cnt + 2'd1;
        end
      end

      if (bus.flush) begin
        pend_valid <= 1'b0;
      end else if (bus.asking && (state == READ) && !(complete && !pend_valid)) begin
        pend_valid <= 1'b1;
        pend_addr  <= bus.addr[AW-1:0];
      end else if (complete) begin
        pend_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: directed scenarios plus random traffic, checked every
// cycle against a transaction-level model of request timing and RAM contents.
module tb_imem_responder;
  localparam int AW = 17;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_responder_if #(.MEM_ADDR_BITS(AW)) bus ();

  imem_responder #(.MEM_ADDR_BITS(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] ram [0:(1<<AW)-1];
  always @(posedge clk) bus.mem_din <= ram[bus.mem_a];

  int n_checks = 0;
  int n_pass   = 0;
  int n_pulse  = 0;

  bit          m_active, m_pv, m_ready;
  logic [AW-1:0] m_base, m_pend;
  int unsigned m_k;
  logic [31:0] m_data = '0;

  function automatic logic [31:0] word_at(input logic [AW-1:0] b);
    logic [AW-1:0] i1, i2, i3;
    i1 = b + 1'b1;
    i2 = b + 2'd2;
    i3 = b + 2'd3;
    if (ram[b][1:0] == 2'b11) return {ram[i3], ram[i2], ram[i1], ram[b]};
    return {16'h0000, ram[i1], ram[b]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic m_start(input logic [AW-1:0] a);
    m_active = 1'b1;
    m_base   = a;
    m_k      = 0;
  endtask

  // One clock edge of the reference: a request spans 4 edges (2-byte) or 6 edges (4-byte).
  task automatic model_edge();
    bit full;
    m_ready = 1'b0;
    if (rst) begin
      m_active = 1'b0;
      m_pv     = 1'b0;
      m_data   = '0;
    end else if (bus.flush) begin
      m_active = 1'b0;
      m_pv     = 1'b0;
      if (bus.asking) m_start(bus.addr[AW-1:0]);
    end else begin
      if (m_active) begin
        m_k++;
        full = (ram[m_base][1:0] == 2'b11);
        if ((!full && m_k == 3) || m_k == 5) begin
          m_data   = word_at(m_base);
          m_ready  = 1'b1;
          m_active = 1'b0;
          if (m_pv) begin
            m_start(m_pend);
            m_pv = 1'b0;
          end
        end
      end
      if (bus.asking) begin
        if (m_active) begin
          m_pv   = 1'b1;
          m_pend = bus.addr[AW-1:0];
        end else begin
          m_start(bus.addr[AW-1:0]);
        end
      end
    end
  endtask

  task automatic tick();
    logic [AW-1:0] ea;
    bit            rd;
    @(posedge clk);
    #1;
    model_edge();
    if (bus.data_ready === 1'b1) n_pulse++;
    rd = m_active && (m_k <= 3);
    check("data_ready", 32'(bus.data_ready), 32'(m_ready));
    check("busy", 32'(bus.busy), 32'(m_active || m_pv));
    check("mem_rd", 32'(bus.mem_rd), 32'(rd));
    check("data", bus.data, m_data);
    if (rd) begin
      ea = m_base + AW'(m_k);
      check("mem_a", 32'(bus.mem_a), 32'(ea));
    end
  endtask

  task automatic cyc(input logic a, input logic [31:0] ad, input logic fl, input logic r);
    bus.asking = a;
    bus.addr   = ad;
    bus.flush  = fl;
    rst        = r;
    tick();
    bus.asking = 1'b0;
    bus.flush  = 1'b0;
    rst        = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] ra;
    for (int i = 0; i < (1 << AW); i++) ram[i] = 8'($urandom);
    ram['h100] = 8'h13; ram['h101] = 8'h05; ram['h102] = 8'hA0; ram['h103] = 8'h00;
    ram['h200] = 8'h01; ram['h201] = 8'h45;
    ram['h1FFFE] = 8'h97; ram['h1FFFF] = 8'h11; ram['h00000] = 8'h22; ram['h00001] = 8'h33;
    bus.asking = 1'b0; bus.addr = '0; bus.flush = 1'b0; rst = 1'b1;

    // reset state
    cyc(1'b1, 32'h100, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    check("rst_mem_a", 32'(bus.mem_a), 32'h0);

    // full 32-bit instruction
    cyc(1'b1, 32'h100, 1'b0, 1'b0);
    idle(4);
    check("full_not_yet", 32'(bus.data_ready), 32'h0);
    idle(1);
    check("full_ready_lat6", 32'(bus.data_ready), 32'h1);
    check("full_data", bus.data, 32'h00A00513);
    idle(2);
    check("full_data_hold", bus.data, 32'h00A00513);

    // compressed instruction
    cyc(1'b1, 32'h200, 1'b0, 1'b0);
    idle(3);
    check("cmp_ready_lat4", 32'(bus.data_ready), 32'h1);
    check("cmp_data", bus.data, 32'h00004501);
    check("cmp_mem_rd_low", 32'(bus.mem_rd), 32'h0);
    idle(2);

    // flush with simultaneous new request
    n_pulse = 0;
    cyc(1'b1, 32'h100, 1'b0, 1'b0);
    idle(2);
    cyc(1'b1, 32'h300, 1'b1, 1'b0);
    idle(8);
    check("flush_pulses", 32'(n_pulse), 32'd1);
    check("flush_data", bus.data, word_at(AW'(32'h300)));

    // newest pending request wins, issued back to back
    n_pulse = 0;
    cyc(1'b1, 32'h100, 1'b0, 1'b0);
    cyc(1'b1, 32'h104, 1'b0, 1'b0);
    cyc(1'b1, 32'h108, 1'b0, 1'b0);
    idle(3);
    check("pend_first", bus.data, 32'h00A00513);
    check("pend_b2b_mem_a", 32'(bus.mem_a), 32'h108);
    idle(8);
    check("pend_pulses", 32'(n_pulse), 32'd2);
    check("pend_data", bus.data, word_at(AW'(32'h108)));

    // address wrap
    cyc(1'b1, 32'hFFF1FFFE, 1'b0, 1'b0);
    check("wrap_a0", 32'(bus.mem_a), 32'h1FFFE);
    idle(1);
    check("wrap_a1", 32'(bus.mem_a), 32'h1FFFF);
    idle(1);
    check("wrap_a2", 32'(bus.mem_a), 32'h00000);
    idle(1);
    check("wrap_a3", 32'(bus.mem_a), 32'h00001);
    idle(2);
    check("wrap_data", bus.data, 32'h33221197);
    idle(1);

    // reset mid-read
    n_pulse = 0;
    cyc(1'b1, 32'h100, 1'b0, 1'b0);
    idle(1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    check("rstmid_mem_a", 32'(bus.mem_a), 32'h0);
    check("rstmid_data", bus.data, 32'h0);
    check("rstmid_busy", 32'(bus.busy), 32'h0);
    idle(6);
    check("rstmid_pulses", 32'(n_pulse), 32'd0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      ra = $urandom;
      cyc(($urandom_range(3) == 0), ra, ($urandom_range(31) == 0), ($urandom_range(199) == 0));
    end
    idle(10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
